// File: rtl/vend_dispense_sequencer_if.sv
// Vend dispense sequencer bus.
// Groups the vend request strobe with its change-return qualifiers and the
// solenoid/status outputs of the sequencer.
//   master : vend FSM side (drives dis/oN/oD/o2D, observes drives and status)
//   slave  : sequencer side (receives the request, drives solenoids and status)
interface vend_dispense_sequencer_if;
  logic dis;          // vend request strobe (rising edge = one request)
  logic oN;           // return one nickel, qualified by dis
  logic oD;           // return one dime, qualified by dis
  logic o2D;          // return two dimes, qualified by dis
  logic can_sol;      // can-release solenoid
  logic nickel_sol;   // nickel-ejector solenoid
  logic dime_sol;     // dime-ejector solenoid
  logic busy;         // sequencer not idle
  logic vend_done;    // one-cycle pulse at the end of a vend
  logic overrun_err;  // sticky: a request was dropped

  modport master (
    output dis, oN, oD, o2D,
    input  can_sol, nickel_sol, dime_sol, busy, vend_done, overrun_err
  );

  modport slave (
    input  dis, oN, oD, o2D,
    output can_sol, nickel_sol, dime_sol, busy, vend_done, overrun_err
  );
endinterface

// File: rtl/vend_dispense_sequencer.sv
// Vend dispense sequencer.
// On each rising edge of dis the sequencer releases a can, then ejects the
// requested nickel (0..1) and dimes (0..3) one pulse at a time, with a dead
// time after every pulse, and flags completion with a one-cycle vend_done.
// One further request can wait in a pending slot; more are dropped and set the
// sticky overrun_err flag.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : vend_dispense_sequencer_if.slave (request in, solenoids/status out)
// Parameters:
//   PULSE_CYC : solenoid on-time in clk cycles (1..255)
//   GAP_CYC   : dead time after each pulse in clk cycles (1..255)
module vend_dispense_sequencer #(
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  vend_dispense_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CAN_ON, CAN_GAP, NKL_ON, NKL_GAP, DIM_ON, DIM_GAP, DONE
  } state_t;

  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        nickels_q, nickels_d;
  logic [1:0]  dimes_q, dimes_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_nkl_q, pend_nkl_d;
  logic [1:0]  pend_dim_q, pend_dim_d;
  logic        dis_q;
  logic        ovr_q, ovr_d;
  logic        can_q, can_d;
  logic        nkl_sol_q, nkl_sol_d;
  logic        dim_sol_q, dim_sol_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        tmr_done;
  logic        req_nkl;
  logic [1:0]  req_dim;

  // Coin selection after any gap: nickels first, then dimes, then finish.
  function automatic state_t after_gap(input logic nkl, input logic [1:0] dim);
    if (nkl)             return NKL_ON;
    else if (dim != 2'd0) return DIM_ON;
    else                 return DONE;
  endfunction

  always_comb begin
    accept   = bus.dis & ~dis_q;
    tmr_done = (timer_q == 8'd0);
    req_nkl  = bus.oN;
    req_dim  = {1'b0, bus.oD} + {bus.o2D, 1'b0};

    state_d    = state_q;
    timer_d    = tmr_done ? timer_q : timer_q - 8'd1;
    nickels_d  = nickels_q;
    dimes_d    = dimes_q;
    pend_vld_d = pend_vld_q;
    pend_nkl_d = pend_nkl_q;
    pend_dim_d = pend_dim_q;
    ovr_d      = ovr_q;

    case (state_q)
      // IDLE and DONE both start the pending vend if there is one; a request
      // arriving in the same cycle refills the slot being emptied.
      IDLE, DONE: begin
        if (pend_vld_q) begin
          state_d    = CAN_ON;
          nickels_d  = pend_nkl_q;
          dimes_d    = pend_dim_q;
          pend_vld_d = accept;
          if (accept) begin
            pend_nkl_d = req_nkl;
            pend_dim_d = req_dim;
          end
        end else if (state_q == IDLE) begin
          if (accept) begin
            state_d   = CAN_ON;
            nickels_d = req_nkl;
            dimes_d   = req_dim;
          end
        end else begin
          state_d = IDLE;
          if (accept) begin
            pend_vld_d = 1'b1;
            pend_nkl_d = req_nkl;
            pend_dim_d = req_dim;
          end
        end
      end
      CAN_ON:  if (tmr_done) state_d = CAN_GAP;
      NKL_ON:  if (tmr_done) begin
        state_d   = NKL_GAP;
        nickels_d = 1'b0;
      end
      DIM_ON:  if (tmr_done) begin
        state_d = DIM_GAP;
        dimes_d = dimes_q - 2'd1;
      end
      CAN_GAP, NKL_GAP, DIM_GAP: if (tmr_done) state_d = after_gap(nickels_q, dimes_q);
      default: state_d = IDLE;
    endcase

    // Requests during an active vend go to the slot, or are dropped if full.
    if (accept && state_q != IDLE && state_q != DONE) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_nkl_d = req_nkl;
        pend_dim_d = req_dim;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // Phase timer reloads on every state change; ON and GAP always alternate,
    // so no state is ever re-entered from itself.
    if (state_d != state_q) begin
      case (state_d)
        CAN_ON, NKL_ON, DIM_ON:    timer_d = PULSE_LD;
        CAN_GAP, NKL_GAP, DIM_GAP: timer_d = GAP_LD;
        default:                   timer_d = 8'd0;
      endcase
    end

    // Outputs are registered from the next state so they align with it.
    can_d     = (state_d == CAN_ON);
    nkl_sol_d = (state_d == NKL_ON);
    dim_sol_d = (state_d == DIM_ON);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= 8'd0;
      nickels_q  <= 1'b0;
      dimes_q    <= 2'd0;
      pend_vld_q <= 1'b0;
      pend_nkl_q <= 1'b0;
      pend_dim_q <= 2'd0;
      dis_q      <= 1'b0;
      ovr_q      <= 1'b0;
      can_q      <= 1'b0;
      nkl_sol_q  <= 1'b0;
      dim_sol_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      nickels_q  <= nickels_d;
      dimes_q    <= dimes_d;
      pend_vld_q <= pend_vld_d;
      pend_nkl_q <= pend_nkl_d;
      pend_dim_q <= pend_dim_d;
      dis_q      <= bus.dis;
      ovr_q      <= ovr_d;
      can_q      <= can_d;
      nkl_sol_q  <= nkl_sol_d;
      dim_sol_q  <= dim_sol_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.can_sol     = can_q;
  assign bus.nickel_sol  = nkl_sol_q;
  assign bus.dime_sol    = dim_sol_q;
  assign bus.busy        = busy_q;
  assign bus.vend_done   = done_q;
  assign bus.overrun_err = ovr_q;

endmodule
